// File: rtl/pipe_stage_skid.sv
// Multi-lane pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall/flush performance counters.
`timescale 1ns/1ps

module pipe_stage_skid_lane #(
    parameter int DATA_W      = 96,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld_m_in,
    input  logic              ld_s_in,
    input  logic              ld_m_s,
    input  logic              out_en,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);
    logic              m_vld, s_vld;
    logic [DATA_W-1:0] m_data, s_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (clr) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else begin
            if (ld_m_in)     m_vld <= in_vld;
            else if (ld_m_s) m_vld <= s_vld;
            if (ld_s_in)     s_vld <= in_vld;
        end
    end

    // Payload is only observed while out_en is high, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ld_m_in)     m_data <= in_data;
        else if (ld_m_s) m_data <= s_data;
        if (ld_s_in)     s_data <= in_data;
    end

    assign out_vld  = out_en & m_vld;
    assign out_data = (ZERO_BUBBLE != 0 && !out_en) ? '0 : m_data;
endmodule

module pipe_stage_skid #(
    parameter int LANES       = 2,
    parameter int DATA_W      = 96,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_vld,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_vld,
    output logic [LANES*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]        perf_stall_cnt,
    output logic [CNT_W-1:0]        perf_flush_cnt
`endif
);
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t state, state_nxt;
    logic   acc, pop;
    logic   ld_m_in, ld_s_in, ld_m_s;

    if (LANES < 1 || DATA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_stage_skid: LANES, DATA_W and CNT_W must all be >= 1");
    end

    assign acc       = in_valid & in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_TWO);
        end
    end

    always_comb begin
        state_nxt = state;
        ld_m_in   = 1'b0;
        ld_s_in   = 1'b0;
        ld_m_s    = 1'b0;
        case (state)
            ST_EMPTY: if (acc) begin
                state_nxt = ST_ONE;
                ld_m_in   = 1'b1;
            end
            ST_ONE: begin
                if (acc && pop) begin
                    ld_m_in = 1'b1;
                end else if (acc) begin
                    state_nxt = ST_TWO;
                    ld_s_in   = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: if (pop) begin
                state_nxt = ST_ONE;
                ld_m_s    = 1'b1;
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush wins: any beat accepted this cycle is dropped, a pop still completes.
        if (flush) begin
            state_nxt = ST_EMPTY;
            ld_m_in   = 1'b0;
            ld_s_in   = 1'b0;
            ld_m_s    = 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pipe_stage_skid_lane #(
            .DATA_W      (DATA_W),
            .ZERO_BUBBLE (ZERO_BUBBLE)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (flush),
            .ld_m_in  (ld_m_in),
            .ld_s_in  (ld_s_in),
            .ld_m_s   (ld_m_s),
            .out_en   (out_valid),
            .in_vld   (in_lane_vld[i]),
            .in_data  (in_data[i*DATA_W +: DATA_W]),
            .out_vld  (out_lane_vld[i]),
            .out_data (out_data[i*DATA_W +: DATA_W])
        );
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [1:0]     held_beats;
    logic [CNT_W:0] flush_sum;

    assign held_beats = (state == ST_TWO) ? 2'd2 : (state == ST_ONE) ? 2'd1 : 2'd0;
    assign flush_sum  = {1'b0, perf_flush_cnt} + (CNT_W+1)'(held_beats);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (flush)
                perf_flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end
`endif

    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready && !flush) |=>
        (in_valid && $stable(in_data) && $stable(in_lane_vld)));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=>
        (out_valid && $stable(out_data) && $stable(out_lane_vld)));
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed handshake scenarios plus a random run, all checked
// against a FIFO-of-beats reference model (capacity 2) by a negedge scoreboard monitor.
`timescale 1ns/1ps

module tb_pipe_stage_skid;
    localparam int LANES = 2;
    localparam int DATA_W = 96;
    localparam int CNT_W = 4;
    localparam int BW = LANES * DATA_W;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [LANES-1:0]  in_lane_vld = '0;
    logic [BW-1:0]     in_data = '0;
    logic              in_ready, out_valid;
    logic [LANES-1:0]  out_lane_vld;
    logic [BW-1:0]     out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;
`endif

    pipe_stage_skid #(.LANES(LANES), .DATA_W(DATA_W), .ZERO_BUBBLE(1), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_vld  (in_lane_vld),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_vld (out_lane_vld),
        .out_data     (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0] lv;
        logic [BW-1:0]    d;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;
    int    stall_m = 0;
    int    flush_m = 0;
    bit    was_acc = 1'b0;
    bit    was_flush = 1'b0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_data();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: the stage is a FIFO of at most two beats; head is presented downstream.
    always @(negedge clk) begin : mon
        int sz;
        if (!rst_n) begin
            exp_q.delete();
            stall_m = 0;
            flush_m = 0;
        end else begin
            sz = exp_q.size();
            if (mon_en) begin
                chk("out_valid", BW'(out_valid), BW'(sz > 0));
                chk("in_ready", BW'(in_ready), BW'(sz < 2));
                if (sz > 0) begin
                    chk("out_lane_vld", BW'(out_lane_vld), BW'(exp_q[0].lv));
                    chk("out_data", out_data, exp_q[0].d);
                end else begin
                    chk("bubble_lane_vld", BW'(out_lane_vld), '0);
                    chk("bubble_data", out_data, '0);
                end
`ifdef PIPE_STAGE_PERF_EN
                chk("perf_stall_cnt", BW'(perf_stall_cnt), BW'(stall_m));
                chk("perf_flush_cnt", BW'(perf_flush_cnt), BW'(flush_m));
`endif
            end
            if (sz > 0 && !out_ready && stall_m < CMAX) stall_m++;
            if (flush) flush_m = (flush_m + sz > CMAX) ? CMAX : flush_m + sz;
            if (sz > 0 && out_ready) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (in_valid && sz < 2) exp_q.push_back('{lv: in_lane_vld, d: in_data});
        end
    end

    task automatic tick();
        @(negedge clk);
        was_acc   = in_valid && in_ready;
        was_flush = flush;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [BW-1:0] d0, da, db, dc;
        logic [BW-1:0] dead;
        bit held;

        // Reset state
        #1;
        chk("rst_out_valid", BW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_lane_vld", BW'(out_lane_vld), '0);
        chk("rst_in_ready", BW'(in_ready), '0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", BW'(in_ready), BW'(1));
        mon_en = 1'b1;

        // Streaming: 8 back-to-back beats, ready always high
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            in_lane_vld = 2'b11;
            in_data = rnd_data();
            if (b == 0) d0 = in_data;
            tick();
            chk("stream_in_ready", BW'(in_ready), BW'(1));
            if (b == 0) begin
                chk("stream_latency_valid", BW'(out_valid), BW'(1));
                chk("stream_latency_data", out_data, d0);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();

        // Backpressure: A on the output, B in the skid, C waits
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_lane_vld = 2'b11;
        da = rnd_data(); db = rnd_data(); dc = rnd_data();
        in_data = da; tick();
        in_data = db; tick();
        chk("bp_in_ready_low", BW'(in_ready), '0);
        chk("bp_hold_a", out_data, da);
        in_data = dc; tick();
        chk("bp_in_ready_still_low", BW'(in_ready), '0);
        chk("bp_hold_a_again", out_data, da);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", out_data, db);
        tick();
        chk("bp_out_c", out_data, dc);
        in_valid = 1'b0;
        tick();
        tick();

        // Flush while two beats are held and a new beat is offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = rnd_data(); tick();
        in_data = rnd_data(); tick();
        in_data = rnd_data();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", BW'(out_valid), '0);
        chk("flush_in_ready", BW'(in_ready), BW'(1));
`ifdef PIPE_STAGE_PERF_EN
        chk("flush_perf_cnt", BW'(perf_flush_cnt), BW'(2));
`endif
        tick();
        tick();

        // Lane bubble: only lane 0 valid, lane 1 carries a marker
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_lane_vld = 2'b01;
        dead = rnd_data();
        dead[DATA_W +: DATA_W] = 96'hDEAD;
        in_data = dead;
        tick();
        in_valid = 1'b0;
        chk("bubble_beat_valid", BW'(out_valid), BW'(1));
        chk("bubble_lane_mask", BW'(out_lane_vld), BW'(2'b01));
        chk("bubble_lane1_data", BW'(out_data[DATA_W +: DATA_W]), BW'(96'hDEAD));
        tick();

        // Asynchronous reset while two beats are held
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_lane_vld = 2'b11;
        in_data = rnd_data(); tick();
        in_data = rnd_data(); tick();
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", BW'(out_valid), '0);
        chk("midrst_out_data", out_data, '0);
        chk("midrst_lane_vld", BW'(out_lane_vld), '0);
        chk("midrst_in_ready", BW'(in_ready), '0);
`ifdef PIPE_STAGE_PERF_EN
        chk("midrst_perf_stall", BW'(perf_stall_cnt), '0);
        chk("midrst_perf_flush", BW'(perf_flush_cnt), '0);
`endif
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready_release", BW'(in_ready), BW'(1));
        mon_en = 1'b1;

        // Long stall: stall counter must saturate and hold
        in_valid = 1'b1;
        in_data = rnd_data();
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_stall_sat", BW'(perf_stall_cnt), BW'(CMAX));
        tick();
        chk("perf_stall_sat_hold", BW'(perf_stall_cnt), BW'(CMAX));
`endif
        chk("stall_still_valid", BW'(out_valid), BW'(1));
        out_ready = 1'b1;
        tick();

        // Random traffic: upstream holds an offered beat until it is taken or flushed
        was_acc = 1'b0;
        was_flush = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            held = in_valid && !was_acc && !was_flush;
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_lane_vld = LANES'($urandom);
                in_data = rnd_data();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 29) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drained_empty", BW'(out_valid), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
